// File: rtl/digital_clock_pkg.sv
// Shared definitions for the digital clock button path: scheduler state encoding,
// push-button indices and default timing constants derived from the system clock.
package digital_clock_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StClear,
        StHoldoff
    } sched_state_e;

    // Push-button requester indices into the latch bank
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_INC  = 1;
    localparam int unsigned BTN_DEC  = 2;
    localparam int unsigned BTN_SET  = 3;
    localparam int unsigned NUM_BTN  = 4;

    // System clock and the default cycle counts it implies
    localparam int unsigned SYS_CLK_HZ             = 1_000_000;
    localparam int unsigned DEFAULT_LOCKOUT_CYCLES = SYS_CLK_HZ / 62_500; // 16 us
    localparam int unsigned DEFAULT_REPEAT_DELAY   = SYS_CLK_HZ / 4;      // 250 ms
    localparam int unsigned DEFAULT_REPEAT_PERIOD  = SYS_CLK_HZ / 20;     // 50 ms

    // True when value can be loaded into a counter of the given width
    function automatic bit fits_width(input longint unsigned value, input int unsigned width);
        if (width >= 64) begin
            return 1'b1;
        end
        return value < (64'(1) << width);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first pending request after the
// previous grant, wrapping around. Reusable for any requester count >= 2.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic [ID_W-1:0]  o_grant,
    output logic             o_valid
);

    logic [ID_W-1:0] w_idx;

    // Scan from the farthest candidate down to the nearest so the nearest hit wins
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = ID_W'((32'(i_last_grant) + 32'(k)) % N_REQ);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_request_scheduler.sv
// Round-robin scheduler sharing the time-setting datapath among latched push-button
// requests. Grants one request, issues it over valid/ready, clears the latch once the
// button is released and then enforces a lockout before the next grant.
// Optional feature: define AUTO_REPEAT_EN to re-issue a held button's command after
// REPEAT_DELAY cycles and every REPEAT_PERIOD cycles thereafter.
module button_request_scheduler
    import digital_clock_pkg::*;
#(
    parameter int unsigned N_REQ          = NUM_BTN,
    parameter int unsigned ID_W           = $clog2(N_REQ),
    parameter int unsigned LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES,
    parameter int unsigned REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_latch_reset,
    output logic             o_cmd_valid,
    output logic [ID_W-1:0]  o_cmd_id,
    input  logic             i_cmd_ready,
    output logic             o_busy
);

    // Reject configurations whose counts cannot be held by the counter
    if (N_REQ < 2 ||
        !fits_width(64'(LOCKOUT_CYCLES), CNT_W) ||
        !fits_width(64'(REPEAT_DELAY), CNT_W) ||
        !fits_width(64'(REPEAT_PERIOD), CNT_W)) begin : g_cfg_err
        $error("button_request_scheduler: invalid N_REQ or cycle count exceeds CNT_W");
    end

    sched_state_e     r_state;
    logic [N_REQ-1:0] r_latch_reset;
    logic             r_cmd_valid;
    logic [ID_W-1:0]  r_cmd_id;
    logic [ID_W-1:0]  r_last_grant;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
`ifdef AUTO_REPEAT_EN
    logic             r_repeat;
`endif

    logic [ID_W-1:0]  w_grant;
    logic             w_grant_valid;
    logic             w_req_held;
    logic             w_cnt_last;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .i_req        (i_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_grant_valid)
    );

    // Level of the granted button's latch, and counter expiring on this cycle
    assign w_req_held = i_req[r_cmd_id];
    assign w_cnt_last = (r_cnt <= CNT_W'(1));

    // Scheduler FSM; every output is a register updated here
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_latch_reset <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_id      <= '0;
            r_last_grant  <= ID_W'(N_REQ - 1);
            r_busy        <= 1'b0;
            r_cnt         <= '0;
`ifdef AUTO_REPEAT_EN
            r_repeat      <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_valid) begin
                        r_cmd_id    <= w_grant;
                        r_cmd_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (i_cmd_ready) begin
                        r_last_grant  <= r_cmd_id;
                        r_cmd_valid   <= 1'b0;
                        r_latch_reset <= N_REQ'(1) << r_cmd_id;
                        r_state       <= StClear;
`ifdef AUTO_REPEAT_EN
                        r_cnt <= r_repeat ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
`endif
                    end
                end
                StClear: begin
                    if (!w_req_held) begin
                        r_latch_reset <= '0;
`ifdef AUTO_REPEAT_EN
                        r_repeat      <= 1'b0;
`endif
                        if (LOCKOUT_CYCLES == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            r_cnt   <= CNT_W'(LOCKOUT_CYCLES);
                            r_state <= StHoldoff;
                        end
                    end
`ifdef AUTO_REPEAT_EN
                    else if (w_cnt_last) begin
                        // Held long enough: re-issue the same id, bypassing arbitration
                        r_latch_reset <= '0;
                        r_cmd_valid   <= 1'b1;
                        r_repeat      <= 1'b1;
                        r_state       <= StIssue;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
`endif
                end
                StHoldoff: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_cnt_last) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_latch_reset = r_latch_reset;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_id      = r_cmd_id;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_button_request_scheduler.sv
// Self-checking bench for button_request_scheduler (default build, no auto-repeat).
// Each request is walked through grant, optional stall, hold and lockout while the
// bench predicts every output from the scheduling rules.
module tb_button_request_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned L = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         ready;
    logic [N-1:0] req;
    logic [N-1:0] latch_rst;
    logic         valid;
    logic [1:0]   id;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int last_g  = N - 1;

    always #5 clk = ~clk;

    button_request_scheduler #(
        .N_REQ          (N),
        .ID_W           (2),
        .LOCKOUT_CYCLES (L),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (10),
        .CNT_W          (32)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_req         (req),
        .o_latch_reset (latch_rst),
        .o_cmd_valid   (valid),
        .o_cmd_id      (id),
        .i_cmd_ready   (ready),
        .o_busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Nearest pending requester after the last grant, by circular distance
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = N + 1;
        for (int j = 0; j < N; j++) begin
            d = (j - last - 1 + 2 * N) % N;
            if (r[j] && d < best_d) begin
                best_d = d;
                best   = j;
            end
        end
        return best;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req = '0;
            tick();
            check("idle_valid", 32'(valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_latch", 32'(latch_rst), 32'd0);
        end
    endtask

    // One full service of a request vector presented while the scheduler is idle
    task automatic do_request(input logic [N-1:0] rv, input int n_stall, input int n_hold,
                              input bit do_rst);
        int           g;
        logic [N-1:0] oh;
        g  = rr_pick(rv, last_g);
        oh = N'(1) << g;

        req   = rv;
        ready = 1'($urandom_range(0, 1));
        tick();
        check("grant_valid", 32'(valid), 32'd1);
        check("grant_id", 32'(id), 32'(g));
        check("grant_busy", 32'(busy), 32'd1);
        check("grant_latch", 32'(latch_rst), 32'd0);

        if (do_rst) begin
            rst = 1'b1;
            tick();
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_id", 32'(id), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_latch", 32'(latch_rst), 32'd0);
            rst    = 1'b0;
            last_g = N - 1;
            return;
        end

        for (int i = 0; i < n_stall; i++) begin
            ready = 1'b0;
            req   = N'($urandom);
            tick();
            check("stall_valid", 32'(valid), 32'd1);
            check("stall_id", 32'(id), 32'(g));
            check("stall_latch", 32'(latch_rst), 32'd0);
        end

        ready = 1'b1;
        req   = N'($urandom);
        tick();
        check("xfer_valid", 32'(valid), 32'd0);
        check("xfer_latch", 32'(latch_rst), 32'(oh));
        check("xfer_busy", 32'(busy), 32'd1);
        last_g = g;

        for (int i = 0; i < n_hold; i++) begin
            ready = 1'($urandom_range(0, 1));
            req   = N'($urandom) | oh;
            tick();
            check("hold_latch", 32'(latch_rst), 32'(oh));
            check("hold_valid", 32'(valid), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end

        req = N'($urandom) & ~oh;
        tick();
        check("release_latch", 32'(latch_rst), 32'd0);
        check("release_busy", 32'(busy), 32'd1);

        for (int i = 1; i < L; i++) begin
            req = N'($urandom);
            tick();
            check("lockout_busy", 32'(busy), 32'd1);
            check("lockout_valid", 32'(valid), 32'd0);
        end

        req = N'($urandom);
        tick();
        check("done_busy", 32'(busy), 32'd0);
        check("done_valid", 32'(valid), 32'd0);
        check("done_latch", 32'(latch_rst), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        ready = 1'b0;
        tick();
        tick();
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_id", 32'(id), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_latch", 32'(latch_rst), 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // Fairness: all pending, instant release -> 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            do_request(4'b1111, 0, 0, 1'b0);
        end

        // Single press of button 1 held 5 cycles into the clear
        do_request(4'b0010, 0, 5, 1'b0);

        // Backpressure for 10 cycles
        do_request(4'b1000, 10, 0, 1'b0);

        // Held button without auto-repeat: one command, latch clear for 1000 cycles
        do_request(4'b0001, 0, 1000, 1'b0);

        // Reset while the command is valid, then re-grant the still-pending request
        do_request(4'b0100, 0, 0, 1'b1);
        do_request(4'b0100, 0, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            do_request(N'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
